// File: rtl/chi_stream_pkg.sv
// Field constants, FSM state encoding and mod-F_Q helpers shared by the chi/dot-product stream.
package chi_stream_pkg;

  localparam int F_NBITS = 16;
  localparam logic [F_NBITS-1:0] F_Q = 16'd65521;
  // 2 - (2^F_NBITS mod F_Q), so that ~t + F_Q_P2_MI == 1 - t (mod F_Q)
  localparam logic [F_NBITS-1:0] F_Q_P2_MI = 16'd65508;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {IDLE, EXPAND, DOT, DRAIN} chi_state_e;

  function automatic logic [F_NBITS-1:0] f_add(input logic [F_NBITS-1:0] a, input logic [F_NBITS-1:0] b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
    return s[F_NBITS-1:0];
  endfunction

  function automatic logic [F_NBITS-1:0] f_sub(input logic [F_NBITS-1:0] a, input logic [F_NBITS-1:0] b);
    return (a >= b) ? (a - b) : (a + (F_Q - b));
  endfunction

  function automatic logic [F_NBITS-1:0] f_one_minus(input logic [F_NBITS-1:0] t);
    logic [F_NBITS+1:0] s;
    s = {2'b00, ~t} + {2'b00, F_Q_P2_MI};
    if (s >= {2'b00, F_Q}) s = s - {2'b00, F_Q};
    if (s >= {2'b00, F_Q}) s = s - {2'b00, F_Q};
    return s[F_NBITS-1:0];
  endfunction

  function automatic logic [F_NBITS-1:0] f_mul(input logic [F_NBITS-1:0] a, input logic [F_NBITS-1:0] b);
    logic [2*F_NBITS-1:0] p;
    p = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
    p = p % {{F_NBITS{1'b0}}, F_Q};
    return p[F_NBITS-1:0];
  endfunction

endpackage

// File: rtl/field_mul_pipe.sv
// Pipelined a*b mod F_Q: one operand pair per cycle, result and valid after mulLatency cycles.
// No backpressure; the valid bit simply travels with the data.
module field_mul_pipe
  import chi_stream_pkg::*;
#(
  parameter int mulLatency = 3
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               op_valid,
  input  logic [F_NBITS-1:0] op_a,
  input  logic [F_NBITS-1:0] op_b,
  output logic               res_valid,
  output logic [F_NBITS-1:0] res
);

  logic               v_pipe [mulLatency];
  logic [F_NBITS-1:0] d_pipe [mulLatency];

  always_ff @(posedge clk) begin
    if (!rstb) begin
      for (int s = 0; s < mulLatency; s++) v_pipe[s] <= 1'b0;
    end else begin
      v_pipe[0] <= op_valid;
      for (int s = 1; s < mulLatency; s++) v_pipe[s] <= v_pipe[s-1];
    end
  end

  always_ff @(posedge clk) begin
    d_pipe[0] <= f_mul(op_a, op_b);
    for (int s = 1; s < mulLatency; s++) d_pipe[s] <= d_pipe[s-1];
  end

  assign res_valid = v_pipe[mulLatency-1];
  assign res       = d_pipe[mulLatency-1];

endmodule

// File: rtl/verifier_chi_dotp_stream.sv
// Expands tau into the Lagrange table chi, then streams value beats and returns sum chi[j]*v[j] per channel.
// vals_ready is high only in DOT; results appear with ready after the multiplier and tree pipeline drains.
module verifier_chi_dotp_stream
  import chi_stream_pkg::*;
#(
  parameter int nValBits   = 3,
  parameter int nParBits   = 1,
  parameter int nChannels  = 2,
  parameter int mulLatency = 3
) (
  input  logic                                                clk,
  input  logic                                                rstb,
  input  logic                                                start,
  input  logic [nValBits-1:0][F_NBITS-1:0]                    tau,
  input  logic [nChannels-1:0][(1<<nParBits)-1:0][F_NBITS-1:0] vals_in,
  input  logic                                                vals_valid,
  output logic                                                vals_ready,
  output logic [nChannels-1:0][F_NBITS-1:0]                   dot_product_out,
  output logic                                                ready
);

  localparam int L      = 1 << nParBits;
  localparam int TBL    = 1 << nValBits;
  localparam int NBEATS = 1 << (nValBits - nParBits);

  chi_state_e                           state;
  logic [nValBits-1:0][F_NBITS-1:0]     tau_q;
  logic [F_NBITS-1:0]                   chi [TBL];
  logic [CNT_W-1:0]                     rnd, icnt, bcnt, dcnt;
  logic [nChannels-1:0][F_NBITS-1:0]    acc, tsum, tsum_n;
  logic                                 tv, dv;

  logic                m_vld  [nChannels][L];
  logic [F_NBITS-1:0]  m_a    [nChannels][L];
  logic [F_NBITS-1:0]  m_b    [nChannels][L];
  logic                m_ovld [nChannels][L];
  logic [F_NBITS-1:0]  m_p    [nChannels][L];

  logic [CNT_W-1:0]    rsize, n_iss, idx;
  logic                last_cyc, to_dot, beat_acc;
  logic [F_NBITS-1:0]  t_cur;
  logic                iss_ok [L];
  logic [nValBits-1:0] k_idx  [L];
  logic [nValBits-1:0] d_idx  [L];
  logic [nValBits-1:0] w_even [L];
  logic [nValBits-1:0] w_odd  [L];

  logic [nValBits-1:0] ek_pipe [mulLatency][L];
  logic [F_NBITS-1:0]  ec_pipe [mulLatency][L];

  // Round r reads chi[k] for k descending, so every write (indices 2k, 2k+1 >= k) lands above any unread entry.
  always_comb begin
    rsize    = CNT_W'(1) << rnd;
    n_iss    = (rsize + CNT_W'(L-1)) >> nParBits;
    last_cyc = (icnt == n_iss + CNT_W'(mulLatency-1));
    to_dot   = (state == EXPAND) &&
               (((rnd == '0) && (nValBits == 1)) ||
                ((rnd != '0) && last_cyc && (rnd == CNT_W'(nValBits-1))));
    beat_acc = vals_valid && vals_ready && (state == DOT);
    t_cur    = '0;
    for (int i = 0; i < nValBits; i++)
      if (rnd == CNT_W'(nValBits-1-i)) t_cur = tau_q[i];
    idx = '0;
    for (int p = 0; p < L; p++) begin
      idx       = (icnt << nParBits) + CNT_W'(p);
      iss_ok[p] = (state == EXPAND) && (rnd != '0) && (icnt < n_iss) && (idx < rsize);
      k_idx[p]  = nValBits'(rsize - CNT_W'(1) - idx);
      d_idx[p]  = nValBits'((bcnt << nParBits) + CNT_W'(p));
      w_even[p] = ek_pipe[mulLatency-1][p] << 1;
      w_odd[p]  = w_even[p] | nValBits'(1);
    end
  end

  always_comb begin
    for (int c = 0; c < nChannels; c++)
      for (int p = 0; p < L; p++) begin
        m_vld[c][p] = 1'b0;
        m_a[c][p]   = '0;
        m_b[c][p]   = '0;
      end
    if (state == EXPAND) begin
      for (int p = 0; p < L; p++) begin
        m_vld[0][p] = iss_ok[p];
        m_a[0][p]   = t_cur;
        m_b[0][p]   = chi[k_idx[p]];
      end
    end else if (state == DOT) begin
      for (int c = 0; c < nChannels; c++)
        for (int p = 0; p < L; p++) begin
          m_vld[c][p] = beat_acc;
          m_a[c][p]   = chi[d_idx[p]];
          m_b[c][p]   = vals_in[c][p];
        end
    end
  end

  for (genvar gc = 0; gc < nChannels; gc++) begin : g_ch
    for (genvar gp = 0; gp < L; gp++) begin : g_lane
      field_mul_pipe #(.mulLatency(mulLatency)) u_mul (
        .clk       (clk),
        .rstb      (rstb),
        .op_valid  (m_vld[gc][gp]),
        .op_a      (m_a[gc][gp]),
        .op_b      (m_b[gc][gp]),
        .res_valid (m_ovld[gc][gp]),
        .res       (m_p[gc][gp])
      );
    end
  end

  always_comb begin
    dv = 1'b0;
    for (int c = 0; c < nChannels; c++) begin
      tsum_n[c] = '0;
      for (int p = 0; p < L; p++) begin
        tsum_n[c] = f_add(tsum_n[c], m_p[c][p]);
        dv        = dv | m_ovld[c][p];
      end
    end
  end

  // chi[k] rides alongside its product so chi[2k] = chi[k] - p can be formed at write time.
  always_ff @(posedge clk) begin
    for (int p = 0; p < L; p++) begin
      ek_pipe[0][p] <= k_idx[p];
      ec_pipe[0][p] <= chi[k_idx[p]];
      for (int s = 1; s < mulLatency; s++) begin
        ek_pipe[s][p] <= ek_pipe[s-1][p];
        ec_pipe[s][p] <= ec_pipe[s-1][p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == EXPAND) begin
      if (rnd == '0) begin
        chi[0] <= f_one_minus(tau_q[nValBits-1]);
        chi[1] <= tau_q[nValBits-1];
      end
      for (int p = 0; p < L; p++) begin
        if (m_ovld[0][p]) begin
          chi[w_odd[p]]  <= m_p[0][p];
          chi[w_even[p]] <= f_sub(ec_pipe[mulLatency-1][p], m_p[0][p]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state           <= IDLE;
      ready           <= 1'b1;
      vals_ready      <= 1'b0;
      dot_product_out <= '0;
      acc             <= '0;
      tsum            <= '0;
      tv              <= 1'b0;
      tau_q           <= '0;
      rnd             <= '0;
      icnt            <= '0;
      bcnt            <= '0;
      dcnt            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tau_q <= tau;
            state <= EXPAND;
            ready <= 1'b0;
            rnd   <= '0;
            icnt  <= '0;
          end
        end
        EXPAND: begin
          if (to_dot) begin
            state      <= DOT;
            vals_ready <= 1'b1;
            bcnt       <= '0;
            icnt       <= '0;
          end else if (rnd == '0) begin
            rnd  <= CNT_W'(1);
            icnt <= '0;
          end else if (last_cyc) begin
            rnd  <= rnd + CNT_W'(1);
            icnt <= '0;
          end else begin
            icnt <= icnt + CNT_W'(1);
          end
        end
        DOT: begin
          if (beat_acc) begin
            bcnt <= bcnt + CNT_W'(1);
            if (bcnt == CNT_W'(NBEATS-1)) begin
              state      <= DRAIN;
              vals_ready <= 1'b0;
              dcnt       <= '0;
            end
          end
        end
        DRAIN: begin
          // multiplier stages, tree register, then the final accumulate
          if (dcnt == CNT_W'(mulLatency+1)) begin
            dot_product_out <= acc;
            ready           <= 1'b1;
            state           <= IDLE;
          end else begin
            dcnt <= dcnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      tv   <= dv && ((state == DOT) || (state == DRAIN));
      tsum <= tsum_n;
      if (to_dot) acc <= '0;
      else if (tv)
        for (int c = 0; c < nChannels; c++) acc[c] <= f_add(acc[c], tsum[c]);
    end
  end

endmodule
